// File: rtl/weight_fifo_in_ctrl_if.sv
// rtl/weight_fifo_in_ctrl_if.sv - row stream, column FIFO write, drain handshake and status bundle
interface weight_fifo_in_ctrl_if #(
  parameter int SYS_ROW    = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int OCC_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int TILE_WIDTH = $clog2(FIFO_DEPTH / SYS_ROW + 1);

  logic                             in_valid;
  logic                             in_ready;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] in_data;
  logic                             in_last;
  logic [FIFO_WIDTH-1:0]            fifo_wen;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] fifo_wdata;
  logic                             drain_en;
  logic                             drain_done;
  logic [OCC_WIDTH-1:0]             occupancy;
  logic [TILE_WIDTH-1:0]            tiles_ready;
  logic                             busy;
  logic                             err_last;

  modport slave (
    input  in_valid, in_data, in_last, drain_done,
    output in_ready, fifo_wen, fifo_wdata, drain_en,
           occupancy, tiles_ready, busy, err_last
  );

  modport master (
    output in_valid, in_data, in_last, drain_done,
    input  in_ready, fifo_wen, fifo_wdata, drain_en,
           occupancy, tiles_ready, busy, err_last
  );
endinterface

// File: rtl/weight_fifo_in_ctrl.sv
// rtl/weight_fifo_in_ctrl.sv - weight FIFO fill controller: row writes, tile counting, drain start
module weight_fifo_in_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_fifo_in_ctrl_if.slave bus
);
  localparam int OCC_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int TILE_WIDTH = $clog2(FIFO_DEPTH / SYS_ROW + 1);
  localparam int ROW_WIDTH  = $clog2(SYS_ROW) + 1;

  localparam logic [ROW_WIDTH-1:0] LAST_ROW  = ROW_WIDTH'(SYS_ROW - 1);
  localparam logic [OCC_WIDTH-1:0] TILE_ROWS = OCC_WIDTH'(SYS_ROW);
  localparam logic [OCC_WIDTH-1:0] DEPTH     = OCC_WIDTH'(FIFO_DEPTH);

  if (FIFO_DEPTH < SYS_ROW || (FIFO_DEPTH % SYS_ROW) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a non-zero multiple of SYS_ROW");
  end

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_e;

  state_e                state_q, state_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [TILE_WIDTH-1:0] tiles_q, tiles_d;
  logic                  err_q, err_d;

  logic accept;
  logic row_is_last;
  logic tile_done;
  logic start;
  logic done;

  assign bus.in_ready   = (occ_q < DEPTH);
  assign accept         = bus.in_valid & bus.in_ready;
  assign row_is_last    = (row_q == LAST_ROW);
  assign tile_done      = accept & row_is_last;
  assign bus.fifo_wen   = {FIFO_WIDTH{accept}};
  assign bus.fifo_wdata = bus.in_data;

  // drain_done only counts while a drain is in flight, so occupancy can never underflow
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tiles_q != '0) begin
          start   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.drain_done) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d   = occ_q;
    row_d   = row_q;
    err_d   = err_q;
    tiles_d = tiles_q + TILE_WIDTH'(tile_done) - TILE_WIDTH'(start);
    if (accept) begin
      occ_d = occ_q + OCC_WIDTH'(1);
      row_d = row_is_last ? '0 : row_q + ROW_WIDTH'(1);
      if (bus.in_last != row_is_last) begin
        err_d = 1'b1;
      end
    end
    if (done) begin
      occ_d = occ_d - TILE_ROWS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      occ_q   <= '0;
      row_q   <= '0;
      tiles_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      row_q   <= row_d;
      tiles_q <= tiles_d;
      err_q   <= err_d;
    end
  end

  assign bus.drain_en    = start;
  assign bus.busy        = (state_q == S_BUSY);
  assign bus.occupancy   = occ_q;
  assign bus.tiles_ready = tiles_q;
  assign bus.err_last    = err_q;
endmodule
